// File: rtl/noc_flit_pkg.sv
// Purpose : flit layout shared by the NoC injection logic (39-bit single-flit packets).
// Latency : n/a (types, field positions and a pack helper only).
// Backpr. : n/a.
// Contents: FLIT_W, field LSB constants, flit_t packed struct, pack_flit().
package noc_flit_pkg;

  localparam int FLIT_W      = 39;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 32;
  localparam int VC_LSB      = 32;
  localparam int DEST_LSB    = 33;
  localparam int DEST_W      = 4;
  localparam int TAIL_LSB    = 37;
  localparam int HEAD_LSB    = 38;

  // Field order matches the LSB constants above: head is bit 38, payload 31:0.
  typedef struct packed {
    logic                 head;
    logic                 tail;
    logic [DEST_W-1:0]    dest;
    logic                 vc;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic flit_t pack_flit(
    input logic                 head,
    input logic                 tail,
    input logic [DEST_W-1:0]    dest,
    input logic                 vc,
    input logic [PAYLOAD_W-1:0] payload
  );
    flit_t f;
    f.head    = head;
    f.tail    = tail;
    f.dest    = dest;
    f.vc      = vc;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first eligible requester starting at i_ptr.
// Latency : purely combinational, grant valid in the same cycle as the request.
// Backpr. : none; caller decides whether the grant is consumed.
// Ports   : i_eligible (N) requests, i_ptr start index,
//           o_grant one-hot, o_grant_idx encoded winner, o_any some request won.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  always_comb begin
    int idx;
    idx         = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    // Walk ptr, ptr+1, ... wrapping; the first hit wins and later hits are ignored.
    for (int off = 0; off < N; off++) begin
      idx = int'(i_ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_eligible[IDX_W'(idx)]) begin
        o_any                  = 1'b1;
        o_grant[IDX_W'(idx)]   = 1'b1;
        o_grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Purpose : shares one router injection port among N_SRC sources (RR, gap, quota).
// Latency : source handshake at edge k -> flit valid right after edge k.
// Backpr. : one-entry output register; grants stall while it is full and not accepted.
// Ports   : clk/rst (async high); en gates new grants; src_valid/src_dest/src_data in,
//           src_ready one-hot grant out; o_data/o_data_valid/i_data_ready router side;
//           o_done all quotas used and idle; o_sent_total flits accepted by the router.
module noc_inject_scheduler
  import noc_flit_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int ADDR_W    = 4,
  parameter int GAP       = 0,
  parameter int PKT_LIMIT = 20,
  parameter int STAMP     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*ADDR_W-1:0] src_dest,
  input  logic [N_SRC*32-1:0]     src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic [FLIT_W-1:0]       o_data,
  output logic                    o_data_valid,
  input  logic                    i_data_ready,
  output logic                    o_done,
  output logic [31:0]             o_sent_total
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = (PKT_LIMIT > 1) ? $clog2(PKT_LIMIT + 1) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(PKT_LIMIT);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  logic             r_vld;
  flit_t            r_flit;
  logic [IDX_W-1:0] r_ptr;
  logic [GAP_W-1:0] r_gap;
  logic [31:0]      r_ts;
  logic [31:0]      r_sent;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt [N_SRC];

  logic [N_SRC-1:0] w_quota_hit;
  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_grant;
  logic [IDX_W-1:0] w_gidx;
  logic             w_any;
  logic             w_can_load;
  logic             w_load;
  logic             w_accept;
  logic             w_all_quota;
  logic [ADDR_W-1:0] w_dest;
  logic [31:0]      w_data;
  logic [31:0]      w_payload;
  flit_t            w_flit;
  logic [IDX_W-1:0] w_ptr_nxt;

  // Counters saturate at LIMIT, so "< LIMIT" is the same as "not yet at quota".
  always_comb begin
    w_quota_hit = '0;
    w_eligible  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      w_quota_hit[s] = (PKT_LIMIT != 0) && !(r_cnt[s] < LIMIT);
      w_eligible[s]  = src_valid[s] && !w_quota_hit[s];
    end
  end

  assign w_all_quota = (PKT_LIMIT != 0) && (&w_quota_hit);

  rr_arbiter #(.N(N_SRC)) u_arb (
    .i_eligible  (w_eligible),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  // Loading is allowed when the register is empty or is being drained this cycle.
  assign w_accept   = r_vld && i_data_ready;
  assign w_can_load = en && (r_gap == '0) && (!r_vld || i_data_ready);
  assign w_load     = w_can_load && w_any;
  assign src_ready  = w_can_load ? w_grant : '0;

  always_comb begin
    w_dest = '0;
    w_data = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (w_grant[s]) begin
        w_dest = src_dest[s*ADDR_W +: ADDR_W];
        w_data = src_data[s*32 +: 32];
      end
    end
  end

  assign w_payload = (STAMP != 0) ? r_ts : w_data;
  assign w_flit    = pack_flit(1'b1, 1'b1, DEST_W'(w_dest), 1'b0, w_payload);
  assign w_ptr_nxt = (w_gidx == IDX_W'(N_SRC - 1)) ? '0 : w_gidx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_flit <= '0;
      r_ptr  <= '0;
      r_gap  <= '0;
      r_ts   <= '0;
      r_sent <= '0;
      r_done <= 1'b0;
      for (int s = 0; s < N_SRC; s++) r_cnt[s] <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_accept) r_sent <= r_sent + 32'd1;

      if (w_load) begin
        // A simultaneous drain is absorbed here: the new flit replaces the old one.
        r_flit <= w_flit;
        r_vld  <= 1'b1;
        r_ptr  <= w_ptr_nxt;
        r_gap  <= GAP_LOAD;
      end else begin
        if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        if (w_accept) r_vld <= 1'b0;
      end

      // Unlimited mode never needs the count, so it is left at zero.
      for (int s = 0; s < N_SRC; s++) begin
        if (w_load && w_grant[s] && (PKT_LIMIT != 0)) r_cnt[s] <= r_cnt[s] + CNT_W'(1);
      end

      if (w_all_quota && !r_vld) r_done <= 1'b1;
    end
  end

  assign o_data       = r_flit;
  assign o_data_valid = r_vld;
  assign o_done       = r_done;
  assign o_sent_total = r_sent;

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Purpose : self-checking bench for noc_inject_scheduler (two configurations).
// Latency : expects flit valid one edge after the source handshake.
// Backpr. : exercises router stall, drain+reload, gap spacing and quota masking.
module tb_noc_inject_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: GAP=0, PKT_LIMIT=20, payload from src_data.
  logic         a_en, a_irdy, a_ovld, a_done;
  logic [3:0]   a_valid, a_srdy;
  logic [15:0]  a_dest;
  logic [127:0] a_data;
  logic [38:0]  a_odata;
  logic [31:0]  a_sent;

  // Instance B: GAP=2, PKT_LIMIT=3, payload = timestamp.
  logic         b_en, b_irdy, b_ovld, b_done;
  logic [3:0]   b_valid, b_srdy;
  logic [15:0]  b_dest;
  logic [127:0] b_data;
  logic [38:0]  b_odata;
  logic [31:0]  b_sent;

  noc_inject_scheduler #(.N_SRC(4), .ADDR_W(4), .GAP(0), .PKT_LIMIT(20), .STAMP(0)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .src_valid(a_valid), .src_dest(a_dest),
    .src_data(a_data), .src_ready(a_srdy), .o_data(a_odata), .o_data_valid(a_ovld),
    .i_data_ready(a_irdy), .o_done(a_done), .o_sent_total(a_sent)
  );

  noc_inject_scheduler #(.N_SRC(4), .ADDR_W(4), .GAP(2), .PKT_LIMIT(3), .STAMP(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .src_valid(b_valid), .src_dest(b_dest),
    .src_data(b_data), .src_ready(b_srdy), .o_data(b_odata), .o_data_valid(b_ovld),
    .i_data_ready(b_irdy), .o_done(b_done), .o_sent_total(b_sent)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [38:0] q_a[$];
  logic [38:0] q_b[$];

  // Cycle count since reset release: the value the timestamp should hold this cycle.
  int tb_ts;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= 0;
    else     tb_ts <= tb_ts + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] mk_flit(input logic [3:0] dest, input logic [31:0] payload);
    return {1'b1, 1'b1, dest, 1'b0, payload};
  endfunction

  function automatic logic [31:0] a_payload(input int s);
    return 32'hC0DE_0000 + 32'(s) * 32'h1111;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every flit accepted by the router must match the head of its queue.
  initial forever begin
    @(negedge clk);
    if (!rst && a_ovld && a_irdy) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_flit: got unexpected flit %0h expected none", a_odata);
      end else check("a_flit", 64'(a_odata), 64'(q_a.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && b_ovld && b_irdy) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_flit: got unexpected flit %0h expected none", b_odata);
      end else check("b_flit", 64'(b_odata), 64'(q_b.pop_front()));
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    int order[3] = '{2, 3, 0};
    int base;
    int src;
    logic [3:0]  exp_sr;
    logic [38:0] held;

    rst = 1'b1;
    a_en = 1'b1; a_valid = '0; a_irdy = 1'b0;
    b_en = 1'b1; b_valid = '0; b_irdy = 1'b0;
    b_data = '1;
    for (int s = 0; s < 4; s++) begin
      a_dest[s*4 +: 4]   = 4'(s + 4);
      b_dest[s*4 +: 4]   = 4'(s + 8);
      a_data[s*32 +: 32] = a_payload(s);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_a_vld",  64'(a_ovld), 64'(0));
    check("rst_a_data", 64'(a_odata), 64'(0));
    check("rst_a_sent", 64'(a_sent), 64'(0));
    check("rst_a_done", 64'(a_done), 64'(0));
    check("rst_a_srdy", 64'(a_srdy), 64'(0));
    check("rst_b_vld",  64'(b_ovld), 64'(0));
    check("rst_b_done", 64'(b_done), 64'(0));
    step();

    // All sources valid, router ready: grants 0,1,2,3,0,1,2,3 back-to-back.
    a_valid = 4'hF; a_irdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_srdy", 64'(a_srdy), 64'(4'b0001 << (i % 4)));
      q_a.push_back(mk_flit(4'(i % 4 + 4), a_payload(i % 4)));
      step();
    end
    a_valid = '0;
    step(); step();
    @(negedge clk);
    check("t1_sent", 64'(a_sent), 64'(8));
    check("t1_vld",  64'(a_ovld), 64'(0));

    // Router stall for 5 cycles with a flit held; source 1 waits meanwhile.
    step();
    a_irdy = 1'b0; a_valid = 4'b0100;
    @(negedge clk);
    check("t2_srdy_first", 64'(a_srdy), 64'(4'b0100));
    held = mk_flit(4'd6, a_payload(2));
    q_a.push_back(held);
    step();
    a_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_data", 64'(a_odata), 64'(held));
      check("t2_hold_vld",  64'(a_ovld), 64'(1));
      check("t2_hold_srdy", 64'(a_srdy), 64'(0));
      check("t2_hold_sent", 64'(a_sent), 64'(8));
      step();
    end
    // Drain and reload in the same cycle.
    a_irdy = 1'b1;
    @(negedge clk);
    check("t2_reload_srdy", 64'(a_srdy), 64'(4'b0010));
    q_a.push_back(mk_flit(4'd5, a_payload(1)));
    step();
    a_valid = '0;
    step();
    @(negedge clk);
    check("t2_sent", 64'(a_sent), 64'(10));
    check("t2_vld",  64'(a_ovld), 64'(0));

    // en low blocks grants; raising it grants source 3.
    step();
    a_en = 1'b0; a_valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("en_low_srdy", 64'(a_srdy), 64'(0));
      check("en_low_vld",  64'(a_ovld), 64'(0));
      step();
    end
    a_en = 1'b1;
    @(negedge clk);
    check("en_high_srdy", 64'(a_srdy), 64'(4'b1000));
    q_a.push_back(mk_flit(4'd7, a_payload(3)));
    step();
    a_valid = '0;
    step();
    @(negedge clk);
    check("en_sent", 64'(a_sent), 64'(11));

    // Reset while a flit is stalled: it is discarded at once; pointer returns to 0.
    step();
    a_irdy = 1'b0; a_valid = 4'b0010;
    @(negedge clk);
    check("t6_srdy", 64'(a_srdy), 64'(4'b0010));
    step();
    a_valid = '0;
    step();
    @(negedge clk);
    check("t6_stall_vld", 64'(a_ovld), 64'(1));
    rst = 1'b1;
    #1;
    check("t6_rst_vld",  64'(a_ovld), 64'(0));
    check("t6_rst_data", 64'(a_odata), 64'(0));
    check("t6_rst_sent", 64'(a_sent), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    a_valid = 4'hF; a_irdy = 1'b1;
    @(negedge clk);
    check("t6_ptr0_srdy", 64'(a_srdy), 64'(4'b0001));
    q_a.push_back(mk_flit(4'd4, a_payload(0)));
    step();
    a_valid = '0;
    step();
    @(negedge clk);
    check("t6_sent", 64'(a_sent), 64'(1));

    // GAP=2, source 1 only: grants and flits spaced 3 cycles, stop at quota 3.
    step();
    b_valid = 4'b0010; b_irdy = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_sr = ((c % 3 == 0) && (c <= 6)) ? 4'b0010 : 4'b0000;
      check("t3_srdy", 64'(b_srdy), 64'(exp_sr));
      check("t3_vld",  64'(b_ovld), 64'((c % 3 == 1) && (c <= 7)));
      if (exp_sr != 4'b0000) q_b.push_back(mk_flit(4'd9, 32'(tb_ts)));
      step();
    end
    b_valid = '0;
    @(negedge clk);
    check("t3_sent", 64'(b_sent), 64'(3));

    // Quota and timestamp: first grant lands in the cycle where ts = 100.
    for (int k = 0; k < 300 && tb_ts != 100; k++) step();
    base = tb_ts;
    b_valid = 4'hF;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      exp_sr = 4'b0000;
      if ((c % 3 == 0) && (c <= 24)) begin
        src = order[(c / 3) % 3];
        exp_sr = 4'b0001 << src;
        q_b.push_back(mk_flit(4'(src + 8), 32'(base + c)));
      end
      check("t4_srdy", 64'(b_srdy), 64'(exp_sr));
      if (c == 1) begin
        held = b_odata;
        check("t5_payload", 64'(held[31:0]), 64'(100));
        check("t5_headtail", 64'(held[38:37]), 64'(2'b11));
        check("t5_vc", 64'(held[32]), 64'(0));
      end
      if (c == 24 || c == 25) check("t4_done_early", 64'(b_done), 64'(0));
      if (c == 29) check("t4_done", 64'(b_done), 64'(1));
      step();
    end
    b_valid = '0;
    @(negedge clk);
    check("t4_sent", 64'(b_sent), 64'(12));
    check("t4_vld",  64'(b_ovld), 64'(0));

    step(); step(); step();
    check("q_a_empty", 64'(q_a.size()), 64'(0));
    check("q_b_empty", 64'(q_b.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
